prog_loader: RTL and testbench

Serial program loader: writer side of the instruction-fetch path. Receives a byte stream through a valid/ready handshake, assembles big-endian 32-bit words, and writes them into instruction memory at consecutive word addresses. Holds the pipeline (`cpu_hold`) until the image is complete, so the fetch unit never reads a partially loaded program.

---
 rtl/prog_loader_if.sv | 21 ++
 rtl/prog_loader.sv | 163 ++++++++++++++++
 tb/tb_prog_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the
// program loader. The master side feeds bytes and observes the writes; the
// slave side is the loader itself.
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader. Takes a big-endian word count followed by that many
// big-endian 32-bit words from a valid/ready byte stream and writes them into
// instruction memory at consecutive word addresses starting at BASE_ADDR.
// cpu_hold stays high until the whole image has landed.
//
// Optional feature macro: LOADER_CHECKSUM_EN -- when defined, a trailing byte
// equal to the XOR of all data bytes must follow the image; a mismatch ends
// in ERR. When undefined the checksum state and accumulator do not exist.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | just out of reset, moves to S_LEN on the next clock
// S_LEN   | collecting the 4 word-count bytes
// S_DATA  | collecting the 4 bytes of the current word
// S_WRITE | one-cycle memory write bubble, advances the word index
// S_CSUM  | collecting the checksum byte (checksum builds only)
// S_DONE  | image complete, CPU released
// S_ERR   | load aborted, CPU held
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  prog_loader_if.slave    bus,
  input  logic            start,
  output logic            cpu_hold,
  output logic            done,
  output logic            err
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         byte_cnt;
  logic [23:0]        shift_q;
  logic [IDX_W-1:0]   n_words;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_inc;
  logic               im_we_q;
  logic [31:0]        im_addr_q;
  logic [31:0]        im_wdata_q;
  logic               rx_ready_c;
  logic               accept;
  logic               last_byte;
  logic               restart;
  logic [31:0]        cur_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         xor_acc;
`endif

  // Words are counted after the header; the current byte completes the
  // big-endian word when byte_cnt is 3 (header or data alike).
  assign rx_ready_c = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign accept     = bus.rx_valid && rx_ready_c;
  assign last_byte  = accept && (byte_cnt == 2'd3);
  assign cur_word   = {shift_q, bus.rx_data};
  assign idx_inc    = idx + 1'b1;
  assign restart    = start && ((state == S_DONE) || (state == S_ERR));

  assign bus.rx_ready = rx_ready_c;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign done         = (state == S_DONE);
  assign err          = (state == S_ERR);
  assign cpu_hold     = (state != S_DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_LEN;
      S_LEN: begin
        if (last_byte) begin
          if (cur_word > 32'(MAX_WORDS)) state_nxt = S_ERR;
          else if (cur_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = S_CSUM;
`else
            state_nxt = S_DONE;
`endif
          end else state_nxt = S_DATA;
        end
      end
      S_DATA: if (last_byte) state_nxt = S_WRITE;
      S_WRITE: begin
        if (idx_inc == n_words) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        end else state_nxt = S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_nxt = (bus.rx_data == xor_acc) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: if (start) state_nxt = S_LEN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte assembly, word index and the registered memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt   <= 2'd0;
      shift_q    <= 24'd0;
      n_words    <= '0;
      idx        <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_wdata_q <= 32'd0;
    end else begin
      im_we_q <= 1'b0;
      if (accept) begin
        shift_q  <= cur_word[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end
      // Counts above MAX_WORDS go to ERR, so the truncated value is never used.
      if ((state == S_LEN) && last_byte) n_words <= cur_word[IDX_W-1:0];
      if ((state == S_DATA) && last_byte) begin
        im_we_q    <= 1'b1;
        im_addr_q  <= BASE_ADDR + (32'(idx) << 2);
        im_wdata_q <= cur_word;
      end
      if (state == S_WRITE) idx <= idx_inc;
      if (restart) begin
        idx      <= '0;
        byte_cnt <= 2'd0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over data bytes only; header bytes never contribute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        xor_acc <= 8'd0;
    else if (restart)                  xor_acc <= 8'd0;
    else if ((state == S_DATA) && accept) xor_acc <= xor_acc ^ bus.rx_data;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of load scenarios driven through
// a byte-level driver, with expected memory writes computed from the image
// contents, plus hand-written reset and restart sequences.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam int unsigned MAXW = 1024;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  prog_loader_if lif();

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (lif),
    .start    (start),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Captured memory writes {addr, data}.
  logic [63:0] wq[$];

  always @(negedge clk) begin
    if (rst_n && lif.im_we === 1'b1) begin
      wq.push_back({lif.im_addr, lif.im_wdata});
      check("ready_low_in_write", {63'd0, lif.rx_ready}, 64'd0);
      check("hold_during_write", {63'd0, cpu_hold}, 64'd1);
    end
  end

  typedef struct {
    int unsigned n;
    int          data_sel;   // 0 fixed pattern, 1 random, 2 bytes 01 02 03 04
    bit          gaps;
    bit          bad_csum;
    bit          start_mid;
    bit          exp_done;
    bit          exp_err;
    int          exp_nw;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] pat[8];

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk);
        lif.rx_valid = 1'b0;
        lif.rx_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    lif.rx_valid = 1'b1;
    lif.rx_data  = b;
    t = 0;
    while (lif.rx_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: rx_ready stayed %b, required 1", lif.rx_ready);
    end
    @(posedge clk);
    #1;
    lif.rx_valid = 1'b0;
    lif.rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic prep();
    if (done || err) begin
      pulse_start();
      check("restart_ready", {63'd0, lif.rx_ready}, 64'd1);
      check("restart_done", {63'd0, done}, 64'd0);
      check("restart_err", {63'd0, err}, 64'd0);
      check("restart_hold", {63'd0, cpu_hold}, 64'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {63'd0, lif.rx_ready}, 64'd0);
    check({tag, "_we"}, {63'd0, lif.im_we}, 64'd0);
    check({tag, "_addr"}, {32'd0, lif.im_addr}, {32'd0, BASE});
    check({tag, "_wdata"}, {32'd0, lif.im_wdata}, 64'd0);
    check({tag, "_hold"}, {63'd0, cpu_hold}, 64'd1);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] words[8];
    logic [7:0]  x;
    logic [7:0]  by;
    int          t;
    x = 8'd0;
    prep();
    wq.delete();
    for (int i = 0; i < 8; i++) begin
      case (v.data_sel)
        0:       words[i] = pat[i];
        1:       words[i] = $urandom;
        default: words[i] = 32'h0102_0304;
      endcase
    end
    for (int b = 0; b < 4; b++) send_byte(8'(v.n >> (24 - 8 * b)), v.gaps);
    if (v.n <= MAXW) begin
      for (int i = 0; i < int'(v.n); i++) begin
        for (int b = 0; b < 4; b++) begin
          if (v.start_mid && i == 0 && b == 2) pulse_start();
          by = 8'(words[i] >> (24 - 8 * b));
          x  = x ^ by;
          send_byte(by, v.gaps);
        end
      end
      if (CSUM) send_byte(v.bad_csum ? (x ^ 8'h01) : x, v.gaps);
    end
    t = 0;
    while (!(done || err) && t < 30) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("final_done", {63'd0, done}, {63'd0, v.exp_done});
    check("final_err", {63'd0, err}, {63'd0, v.exp_err});
    check("final_hold", {63'd0, cpu_hold}, {63'd0, !v.exp_done});
    check("final_ready", {63'd0, lif.rx_ready}, 64'd0);
    check("write_count", 64'(wq.size()), 64'(v.exp_nw));
    for (int i = 0; i < wq.size() && i < 8; i++)
      check("write_addr_data", wq[i], {BASE + 32'(4 * i), words[i]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    lif.rx_valid = 1'b0;
    lif.rx_data  = 8'd0;
    pat = '{32'h1234_5678, 32'h9ABC_DEF0, 32'hDEAD_BEEF, 32'h0000_0001,
            32'h8000_0000, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h0F0F_F0F0};

    vecs[0] = '{n: 2,          data_sel: 0, gaps: 0, bad_csum: 0, start_mid: 0,
                exp_done: 1, exp_err: 0, exp_nw: 2};
    vecs[1] = '{n: 0,          data_sel: 0, gaps: 0, bad_csum: 0, start_mid: 0,
                exp_done: 1, exp_err: 0, exp_nw: 0};
    vecs[2] = '{n: 32'h401,    data_sel: 0, gaps: 0, bad_csum: 0, start_mid: 0,
                exp_done: 0, exp_err: 1, exp_nw: 0};
    vecs[3] = '{n: 1,          data_sel: 2, gaps: 0, bad_csum: 0, start_mid: 0,
                exp_done: 1, exp_err: 0, exp_nw: 1};
    vecs[4] = '{n: 1,          data_sel: 2, gaps: 0, bad_csum: 1, start_mid: 0,
                exp_done: !CSUM, exp_err: CSUM, exp_nw: 1};
    vecs[5] = '{n: 3,          data_sel: 1, gaps: 1, bad_csum: 0, start_mid: 0,
                exp_done: 1, exp_err: 0, exp_nw: 3};
    vecs[6] = '{n: 4,          data_sel: 1, gaps: 1, bad_csum: 0, start_mid: 1,
                exp_done: 1, exp_err: 0, exp_nw: 4};
    vecs[7] = '{n: 32'hFFFF_FFFF, data_sel: 0, gaps: 0, bad_csum: 0, start_mid: 0,
                exp_done: 0, exp_err: 1, exp_nw: 0};
    vecs[8] = '{n: 8,          data_sel: 1, gaps: 1, bad_csum: 0, start_mid: 0,
                exp_done: 1, exp_err: 0, exp_nw: 8};

    // Reset values while reset is held, then first ready after release.
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_ready", {63'd0, lif.rx_ready}, 64'd0);
    @(negedge clk);
    check("len_ready", {63'd0, lif.rx_ready}, 64'd1);

    foreach (vecs[k]) run_load(vecs[k]);

    // Same image twice: once back-to-back, once with random valid gaps.
    begin
      vec_t a;
      a = '{n: 2, data_sel: 0, gaps: 1, bad_csum: 0, start_mid: 0,
            exp_done: 1, exp_err: 0, exp_nw: 2};
      run_load(a);
    end

    // Reset mid-load: N=3, abort after 6 bytes, then a fresh load from the header.
    prep();
    wq.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t r;
      r = '{n: 1, data_sel: 1, gaps: 0, bad_csum: 0, start_mid: 0,
            exp_done: 1, exp_err: 0, exp_nw: 1};
      run_load(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
